alu_mul16_seq: RTL

- Iterative 16x16 -> 32-bit unsigned shift-add multiplier in the ALU.
- Sits directly upstream of the shared 16-bit adder. Each busy cycle it drives the adder operands and consumes the adder's sum and carry-out.
- One adder pass per multiplier bit; no internal adder.
- Consumed by the ALU result mux via a start/ready/done handshake.

---
 rtl/alu_mul16_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/alu_mul16_seq.sv
// alu_mul16_seq: iterative unsigned shift-add multiplier (WIDTH x WIDTH -> 2*WIDTH).
// Borrows the ALU's shared combinational adder: each BUSY cycle it drives
// add_a/add_b and folds add_sum/add_cout back into the partial product.
// Optional early termination is enabled by defining MUL_EARLY_TERM_EN.
module alu_mul16_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   mcand;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod_r;
  logic               early;
  logic               last_iter;

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

`ifdef MUL_EARLY_TERM_EN
  logic [WIDTH-1:0] mrem;

  // Remaining multiplier bits are all zero: every further pass would only
  // add zero and shift, so the whole tail collapses into one shift.
  assign early = (state == BUSY) && (mrem == '0);

  function automatic logic [2*WIDTH-1:0] flush_shift(input logic [2*WIDTH-1:0] v,
                                                      input logic [CNT_W-1:0]   c);
    logic [CNT_W:0] amt;
    amt = (CNT_W+1)'(WIDTH) - {1'b0, c};
    return v >> amt;
  endfunction

  // Shadow copy of the multiplier, consumed one bit per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mrem <= '0;
    end else if (state == IDLE && start) begin
      mrem <= op_b;
    end else if (state == BUSY) begin
      mrem <= mrem >> 1;
    end
  end
`else
  assign early = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and handshake/adder outputs.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    add_a     = '0;
    add_b     = '0;
    product   = prod_r;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = BUSY;
      end
      BUSY: begin
        add_a = hi;
        add_b = lo[0] ? mcand : '0;
        if (early || last_iter) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        product   = {hi, lo};
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, one shift-add pass per BUSY cycle, result capture in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
      cnt    <= '0;
      prod_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= op_a;
            lo    <= op_b;
            hi    <= '0;
            cnt   <= '0;
          end
        end
        BUSY: begin
`ifdef MUL_EARLY_TERM_EN
          if (early) begin
            {hi, lo} <= flush_shift({hi, lo}, cnt);
          end else begin
            {hi, lo} <= {add_cout, add_sum, lo[WIDTH-1:1]};
          end
`else
          {hi, lo} <= {add_cout, add_sum, lo[WIDTH-1:1]};
`endif
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          prod_r <= {hi, lo};
        end
        default: begin
        end
      endcase
    end
  end

endmodule
